// File: rtl/audio_pkg.sv
// Shared constants and FSM encoding for the audio input path.
package audio_pkg;
  localparam int SAMPLE_W = 16;
  localparam int ROWS     = 512;
  localparam int ZERO_RUN = 800;
  localparam int ROW_W    = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;
endpackage

// File: rtl/ser2par.sv
// MSB-first serial-to-parallel shifter: keeps the previous W-1 bits and
// completes the word with the live serial bit, so the full word is ready on the last bit.
module ser2par #(
  parameter int W = 16
) (
  input  logic         Sclk,
  input  logic         Reset_n,
  input  logic         clear,
  input  logic         shift_en,
  input  logic         din,
  output logic [W-1:0] word
);
  logic [W-2:0] hist_r;

  assign word = {hist_r, din};

  // Shift history, cleared by reset or soft clear.
  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      hist_r <= '0;
    end else if (clear) begin
      hist_r <= '0;
    end else if (shift_en) begin
      hist_r <= word[W-2:0];
    end
  end
endmodule

// File: rtl/in_deser.sv
// Stereo input deserializer: assembles one L/R word per frame, writes it with a
// registered strobe at a circular row index, and sleeps after a long run of silent frames.
module in_deser #(
  parameter int SAMPLE_W = audio_pkg::SAMPLE_W,
  parameter int ROWS     = audio_pkg::ROWS,
  parameter int ZERO_RUN = audio_pkg::ZERO_RUN
) (
  input  logic                         Sclk,
  input  logic                         Reset_n,
  input  logic                         clear,
  input  logic                         Frame,
  input  logic                         InputL,
  input  logic                         InputR,
  output logic [SAMPLE_W-1:0]          DataL,
  output logic [SAMPLE_W-1:0]          DataR,
  output logic [audio_pkg::ROW_W-1:0]  row,
  output logic                         in_status,
  output logic                         sleep
);
  import audio_pkg::*;

  localparam int BCNT_W = $clog2(SAMPLE_W);
  localparam int IDX_W  = $clog2(ROWS);
  localparam int ZC_W   = $clog2(ZERO_RUN + 1);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(SAMPLE_W - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(ROWS - 1);
  localparam logic [ZC_W-1:0]   ZC_MAX   = ZC_W'(ZERO_RUN);

  state_e              state_r, state_s;
  logic [BCNT_W-1:0]   bcnt_r, bcnt_s;
  logic                shift_en_s, capture_s, zero_s, write_s;
  logic [SAMPLE_W-1:0] word_l_s, word_r_s;
  logic [SAMPLE_W-1:0] data_l_r, data_r_r;
  logic [ROW_W-1:0]    row_r;
  logic [IDX_W-1:0]    idx_r, idx_nxt_s;
  logic [ZC_W-1:0]     zcnt_r, zcnt_nxt_s;
  logic                in_status_r, sleep_r, written_r, zero_word_r;

  ser2par #(.W(SAMPLE_W)) u_ser_l (
    .Sclk(Sclk), .Reset_n(Reset_n), .clear(clear),
    .shift_en(shift_en_s), .din(InputL), .word(word_l_s)
  );

  ser2par #(.W(SAMPLE_W)) u_ser_r (
    .Sclk(Sclk), .Reset_n(Reset_n), .clear(clear),
    .shift_en(shift_en_s), .din(InputR), .word(word_r_s)
  );

  assign DataL     = data_l_r;
  assign DataR     = data_r_r;
  assign row       = row_r;
  assign in_status = in_status_r;
  assign sleep     = sleep_r;

  // Next state and bit counter; a Frame inside RECV restarts the word.
  always_comb begin
    state_s    = state_r;
    bcnt_s     = bcnt_r;
    shift_en_s = 1'b0;
    capture_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (Frame) begin
          state_s = ST_RECV;
          bcnt_s  = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (Frame) begin
          bcnt_s = '0;
        end else begin
          shift_en_s = 1'b1;
          if (bcnt_r == LAST_BIT) begin
            capture_s = 1'b1;
            state_s   = ST_WRITE;
            bcnt_s    = '0;
          end else begin
            bcnt_s = bcnt_r + BCNT_W'(1);
          end
        end
      end
      ST_WRITE: begin
        bcnt_s = '0;
        if (Frame) begin
          state_s = ST_RECV;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        bcnt_s  = '0;
      end
    endcase
  end

  // Silent words arriving while asleep are counted but never written.
  assign zero_s  = (word_l_s == '0) && (word_r_s == '0);
  assign write_s = capture_s && !(sleep_r && zero_s);

  // Row wrap and saturating silence count, applied when leaving WRITE.
  always_comb begin
    idx_nxt_s  = '0;
    zcnt_nxt_s = '0;
    if (idx_r == LAST_IDX) begin
      idx_nxt_s = '0;
    end else begin
      idx_nxt_s = idx_r + IDX_W'(1);
    end
    if (!zero_word_r) begin
      zcnt_nxt_s = '0;
    end else if (zcnt_r == ZC_MAX) begin
      zcnt_nxt_s = ZC_MAX;
    end else begin
      zcnt_nxt_s = zcnt_r + ZC_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= ST_IDLE;
      bcnt_r  <= '0;
    end else if (clear) begin
      state_r <= ST_IDLE;
      bcnt_r  <= '0;
    end else begin
      state_r <= state_s;
      bcnt_r  <= bcnt_s;
    end
  end

  // Registered outputs, row index and silence tracking.
  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      data_l_r    <= '0;
      data_r_r    <= '0;
      row_r       <= '0;
      idx_r       <= '0;
      zcnt_r      <= '0;
      in_status_r <= 1'b0;
      sleep_r     <= 1'b0;
      written_r   <= 1'b0;
      zero_word_r <= 1'b0;
    end else if (clear) begin
      row_r       <= '0;
      idx_r       <= '0;
      zcnt_r      <= '0;
      in_status_r <= 1'b0;
      sleep_r     <= 1'b0;
      written_r   <= 1'b0;
      zero_word_r <= 1'b0;
    end else begin
      in_status_r <= write_s;
      if (write_s) begin
        data_l_r <= word_l_s;
        data_r_r <= word_r_s;
        row_r    <= ROW_W'(idx_r);
      end
      if (capture_s) begin
        written_r   <= write_s;
        zero_word_r <= zero_s;
      end
      if (state_r == ST_WRITE) begin
        if (written_r) begin
          idx_r <= idx_nxt_s;
        end
        zcnt_r  <= zcnt_nxt_s;
        sleep_r <= (zcnt_nxt_s == ZC_MAX);
      end
    end
  end
endmodule

// File: doc/in_deser.md
IN_DESER -- requirements
Module: in_deser

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16, bits per serial sample word.
REQ-002 SHALL have parameter ROWS, default 512, circular sample-buffer depth.
REQ-003 SHALL have parameter ZERO_RUN, default 800, consecutive all-zero frames before sleep.
REQ-004 Sclk  input  1  single clock; all state updates on rising edge.
REQ-005 Reset_n  input  1  asynchronous, active-low reset.
REQ-006 clear  input  1  synchronous clear of counters and state.
REQ-007 Frame  input  1  one-cycle frame-start strobe.
REQ-008 InputL  input  1  left-channel serial data, MSB first.
REQ-009 InputR  input  1  right-channel serial data, MSB first.
REQ-010 DataL  output  16  assembled left sample, feeds left input memory Input port.
REQ-011 DataR  output  16  assembled right sample, feeds right input memory Input port.
REQ-012 row  output  10  write address for the current sample; bit 9 always 0.
REQ-013 in_status  output  1  one-cycle registered write strobe; a rising edge means DataL/DataR/row are valid.
REQ-014 sleep  output  1  high while input has been silent for ZERO_RUN frames.

Function
REQ-015 States: IDLE, RECV, WRITE.
REQ-016 IDLE: Frame=1 -> RECV, bit counter = 0.
REQ-017 RECV: each cycle shift InputL/InputR into the left/right shift registers, MSB first; bit counter +1.
REQ-018 RECV: after the 16th bit (counter = 15) -> WRITE; sampling occurs in the 16 cycles after the Frame cycle.
REQ-019 WRITE: in_status=1 for exactly one cycle; DataL/DataR = assembled words; row = current index; then -> IDLE.
REQ-020 DataL, DataR and row SHALL be stable from the WRITE cycle until the next WRITE.
REQ-021 Frame during RECV: discard the partial word, restart the bit counter at 0, stay in RECV, no write.
REQ-022 Frame during WRITE: complete the write, then -> RECV (Frame is not lost).
REQ-023 Row index increments in the cycle after WRITE; wraps ROWS-1 (511) -> 0.
REQ-024 Zero-run counter: after each WRITE, if DataL==0 and DataR==0, increment, saturating at ZERO_RUN; else reset to 0.
REQ-025 sleep=1 when the zero-run counter reaches ZERO_RUN; sleep=0 in the cycle after any WRITE with a nonzero sample.
REQ-026 While sleep=1, in_status SHALL stay 0 for all-zero frames; row SHALL not advance; counting continues.
REQ-027 The first nonzero frame in sleep SHALL be written normally (in_status pulse) at the current row.
REQ-028 clear=1: state -> IDLE, row -> 0, zero counter -> 0, sleep -> 0, in_status -> 0; clear overrides Frame.
REQ-029 in_status SHALL come from a flop, glitch-free, because downstream memories clock on it.

Reset
REQ-030 Reset_n low asynchronously forces: state IDLE, DataL=0, DataR=0, row=0, in_status=0, sleep=0, bit and zero counters 0.
REQ-031 Reset mid-RECV discards the partial word; no in_status pulse is produced on release.
REQ-032 After Reset_n rises, the first Frame is accepted on the next rising Sclk edge.

Structure
REQ-033 SAMPLE_W, ROWS, ZERO_RUN and the state encoding SHALL live in a shared package, audio_pkg.
REQ-034 A single sub-module, ser2par, SHALL implement one 16-bit MSB-first shift register with clear; it SHALL be instantiated twice (L, R).
REQ-035 Row and zero-run counters and the FSM SHALL stay in in_deser.

Verification
REQ-036 Frame, then InputL bits 0xA5C3 and InputR bits 0x1234 -> in_status pulses in cycle 17 after Frame; DataL=0xA5C3, DataR=0x1234, row=0.
REQ-037 513 back-to-back frames -> row sequence 0..511, then 0; one in_status pulse per frame.
REQ-038 Frame re-asserted after 7 bits -> no pulse for the aborted word; next full word written at the unchanged row.
REQ-039 800 all-zero frames -> sleep=1 after the 800th write; further zero frames give no pulse; frame with DataL=0x0001 -> pulse, sleep=0.
REQ-040 Reset_n low at bit 9 of RECV -> all outputs 0 immediately; no pulse after release; next frame written at row=0.
REQ-041 clear asserted in the same cycle as Frame at row=37 -> state IDLE, row=0, frame ignored.
